// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR tap sequencer.
package fir_ctrl_pkg;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 64;
  localparam int MAC_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SWEEP,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out handshakes plus the delay-line and MAC controls.
interface fir_tap_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W:0]   ntaps;
  logic              sr_shift;
  logic [DATA_W-1:0] sr_din;
  logic [ADDR_W-1:0] sr_address;
  logic              mac_en;
  logic              mac_clr;
  logic              mac_last;
  logic              busy;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, ntaps, out_ready,
    output in_ready, sr_shift, sr_din, sr_address,
           mac_en, mac_clr, mac_last, busy, out_valid
  );

  modport master (
    output in_valid, in_data, ntaps, out_ready,
    input  in_ready, sr_shift, sr_din, sr_address,
           mac_en, mac_clr, mac_last, busy, out_valid
  );
endinterface

// File: rtl/fir_tap_sequencer_tap_counter.sv
// Up-counter with clear, enable and a terminal-count compare; saturates at the terminal value.
module tap_counter #(
  parameter int WIDTH = 6,
  parameter int CMP_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CMP_W-1:0] last_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Compare at the wider width so a full-depth terminal value still fits.
  assign tc_o  = (CMP_W'(cnt_q) == last_i);
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise step until the terminal count is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accept a sample, shift it in, sweep the taps, drain the MAC, hold the result.
//
// state | meaning
// IDLE  | waiting for a sample (in_ready=1)
// SHIFT | one-cycle push of the captured sample into the delay line
// SWEEP | walk addresses 0..ntaps-1 with mac_en
// DRAIN | wait MAC_LAT cycles for the MAC pipeline
// DONE  | out_valid held until the consumer takes it
module fir_tap_sequencer #(
  parameter int dataWidth = fir_ctrl_pkg::DATA_W,
  parameter int size      = fir_ctrl_pkg::DEPTH,
  parameter int addrWidth = $clog2(size),
  parameter int MAC_LAT   = fir_ctrl_pkg::MAC_LAT
) (
  input logic                clk,
  input logic                rst,
  fir_tap_sequencer_if.slave bus
);
  import fir_ctrl_pkg::*;

  localparam int                 DW     = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;
  localparam logic [addrWidth:0] SIZE_C = (addrWidth + 1)'(size);
  localparam logic [addrWidth:0] ONE_C  = (addrWidth + 1)'(1);

  seq_state_t             state_q, state_d;
  logic [dataWidth-1:0]   data_q, data_d;
  logic [addrWidth:0]     ntaps_q, ntaps_d;
  logic [addrWidth:0]     ntaps_clamped;
  logic [addrWidth:0]     sweep_last;
  logic [addrWidth-1:0]   sweep_cnt;
  logic                   sweep_tc;
  logic                   drain_tc;

  // A zero tap count still produces one MAC cycle; anything past the line depth is cut to it.
  assign ntaps_clamped = (bus.ntaps == '0)    ? ONE_C  :
                         (bus.ntaps > SIZE_C) ? SIZE_C : bus.ntaps;
  assign sweep_last    = ntaps_q - ONE_C;

  tap_counter #(.WIDTH(addrWidth), .CMP_W(addrWidth + 1)) u_sweep_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == SHIFT),
    .en_i   (state_q == SWEEP),
    .last_i (sweep_last),
    .cnt_o  (sweep_cnt),
    .tc_o   (sweep_tc)
  );

  if (MAC_LAT > 0) begin : g_drain
    localparam logic [DW:0] DRAIN_LAST = (DW + 1)'(MAC_LAT - 1);
    logic [DW-1:0] dcnt_unused;
    tap_counter #(.WIDTH(DW), .CMP_W(DW + 1)) u_drain_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q != DRAIN),
      .en_i   (state_q == DRAIN),
      .last_i (DRAIN_LAST),
      .cnt_o  (dcnt_unused),
      .tc_o   (drain_tc)
    );
  end else begin : g_no_drain
    assign drain_tc = 1'b1;
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    ntaps_d        = ntaps_q;
    bus.in_ready   = 1'b0;
    bus.sr_shift   = 1'b0;
    bus.sr_din     = '0;
    bus.sr_address = '0;
    bus.mac_en     = 1'b0;
    bus.mac_clr    = 1'b0;
    bus.mac_last   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = SHIFT;
          data_d  = bus.in_data;
          ntaps_d = ntaps_clamped;
        end
      end
      SHIFT: begin
        bus.sr_shift = 1'b1;
        bus.sr_din   = data_q;
        state_d      = SWEEP;
      end
      SWEEP: begin
        bus.sr_address = sweep_cnt;
        bus.mac_en     = 1'b1;
        bus.mac_clr    = (sweep_cnt == '0);
        bus.mac_last   = sweep_tc;
        if (sweep_tc) state_d = (MAC_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (drain_tc) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured sample and clamped tap count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ntaps_q <= ONE_C;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ntaps_q <= ntaps_d;
    end
  end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Controller that sequences the 64-deep tap-delay shift register (shift_reg) for one FIR output per input sample. It accepts a sample over a valid/ready handshake and shifts it into the delay line. It then sweeps the read address across the active taps while driving the MAC enables, waits for the MAC pipeline to drain, and presents out_valid until the consumer accepts the result.

Parameters:
dataWidth, 16, sample width (matches shift_reg)
size, 64, delay-line depth
addrWidth, $clog2(size) = 6, address width
MAC_LAT, 2, MAC pipeline latency in cycles; 0 allowed

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  upstream sample valid
in_ready  out  1  sequencer can accept a sample
in_data  in  dataWidth  sample
ntaps  in  addrWidth+1  active tap count, sampled at the input handshake
sr_shift  out  1  shift enable to shift_reg
sr_din  out  dataWidth  data to shift_reg din
sr_address  out  addrWidth  tap read address to shift_reg and coefficient ROM
mac_en  out  1  MAC consumes the current product
mac_clr  out  1  first tap: load the product instead of accumulating
mac_last  out  1  final tap of the sweep
busy  out  1  state != IDLE
out_valid  out  1  MAC result valid
out_ready  in  1  downstream accepts the result

Behaviour:
- FSM states, in a shared enum: IDLE, SHIFT, SWEEP, DRAIN, DONE. Outputs are Moore-decoded from state and registers.
- Reset (rst=0, asynchronous) returns to IDLE from any state, including mid-sweep or in DONE. Any in-progress result is discarded.
- Reset values: in_ready=1, all other outputs 0, sr_din=0, counters 0, ntaps_r=1.
- IDLE: in_ready=1. On in_valid&&in_ready, go to SHIFT and capture:
  - in_data into data_r.
  - ntaps clamped into ntaps_r: 0 becomes 1; values above size become size.
- SHIFT (exactly 1 cycle): sr_shift=1, sr_din=data_r, sr_address=0. Next state SWEEP, with cnt=0.
- SWEEP (ntaps_r cycles):
  - sr_address=cnt, mac_en=1.
  - mac_clr=1 only when cnt==0.
  - mac_last=1 when cnt==ntaps_r-1; the sweep exits in that same cycle.
  - With ntaps_r==1, mac_clr and mac_last are both 1 in the single SWEEP cycle.
  - cnt increments each cycle and never wraps past ntaps_r-1.
- Sweep exit: to DRAIN with dcnt=0 if MAC_LAT>0, else directly to DONE.
- DRAIN (MAC_LAT cycles): mac_en=0, sr_address held at 0. Go to DONE when dcnt==MAC_LAT-1.
- DONE: out_valid=1, held until out_ready. On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE; no overlap between a pending result and a new sample.
- in_ready=0 in every non-IDLE state. in_valid is ignored there, and upstream must hold its data until handshake.
- sr_shift is asserted at most once per accepted sample and never outside SHIFT.
- Latency: handshake in cycle t, then SHIFT in t+1, SWEEP in t+2..t+1+N, out_valid first high in t+2+N+MAC_LAT. For N=64, MAC_LAT=2, that is t+68.
- Width rules:
  - cnt is addrWidth bits; ntaps_r is addrWidth+1 bits so it can hold 64.
  - The cnt==ntaps_r-1 compare is done at addrWidth+1 bits.
  - dcnt is $clog2(MAC_LAT+1) bits.

Decomposition:
- fir_ctrl_pkg: state enum seq_state_t; default constants DATA_W=16, DEPTH=64, MAC_LAT=2.
- One sub-module, tap_counter: a parameterized up-counter with clear, enable and terminal-count compare. It is instantiated twice, for the sweep count and the drain count.
- The top-level FSM and handshake logic live in fir_tap_sequencer.

Test Plan:
- Reset: rst=0 at t=31ns for 20ns, released mid-SWEEP -> state IDLE immediately, in_ready=1, sr_shift/mac_en/out_valid=0, next accepted sample restarts at address 0.
- Single sample, ntaps=64, din=16'h0001, out_ready=1 -> sr_shift one cycle with sr_din=16'h0001; sr_address 0..63 in consecutive cycles; mac_clr at address 0, mac_last at 63; out_valid 68 cycles after handshake.
- Boundary ntaps: ntaps=0 and ntaps=1 -> exactly one SWEEP cycle with mac_clr=mac_last=1. ntaps=100 -> clamped to 64 sweep cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid stays 1; in_valid=1 with din=16'hffff is not accepted (in_ready=0) until one cycle after out_ready=1.
- Back-to-back: in_valid held 1 with din 16'h00ff then 16'h0002, ntaps=4, MAC_LAT=2 -> second handshake the cycle after the first DONE->IDLE transition; exactly two sr_shift pulses.
- MAC_LAT=0 build: ntaps=4 -> DRAIN is skipped, out_valid in cycle t+6.
